// File: rtl/mips_decode_alu_unit.sv
// Main control decoder, ALU-control decoder and 32-bit ALU for a five-stage MIPS pipeline,
// with an EX/MEM stage register holding the ALU result and zero flag.
module mips_decode_alu_unit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   opcode,
    output logic         regdst,
    output logic [1:0]   branch,
    output logic         memread,
    output logic         memtoreg,
    output logic [1:0]   aluop,
    output logic         memwrite,
    output logic         alusrc,
    output logic         regwrite,
    input  logic [1:0]   aluop_ex,
    input  logic [5:0]   funct_ex,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [3:0]   aluctl,
    output logic [W-1:0] result,
    output logic         zero,
    input  logic         hold,
    input  logic         clear,
    output logic [W-1:0] result_q,
    output logic         zero_q
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;

    logic [3:0]   w_aluctl;
    logic [W-1:0] w_result;
    logic         w_zero;
    logic [W-1:0] r_result_q;
    logic         r_zero_q;

    // Main control: unknown opcodes decode to a side-effect-free NOP bundle
    always_comb begin
        regdst   = 1'b0;
        branch   = 2'b00;
        memread  = 1'b0;
        memtoreg = 1'b0;
        aluop    = 2'b00;
        memwrite = 1'b0;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regdst   = 1'b1;
                aluop    = 2'b10;
                regwrite = 1'b1;
            end
            OP_LW: begin
                memread  = 1'b1;
                memtoreg = 1'b1;
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_SW: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
            end
            OP_BEQ: begin
                branch = 2'b01;
                aluop  = 2'b01;
            end
            OP_BNE: begin
                branch = 2'b10;
                aluop  = 2'b01;
            end
            OP_ADDI: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU control: only aluop 10 looks at funct; everything unrecognised adds
    always_comb begin
        w_aluctl = CTL_ADD;
        case (aluop_ex)
            2'b01: w_aluctl = CTL_SUB;
            2'b10: begin
                case (funct_ex)
                    6'b100000: w_aluctl = CTL_ADD;
                    6'b100010: w_aluctl = CTL_SUB;
                    6'b100100: w_aluctl = CTL_AND;
                    6'b100101: w_aluctl = CTL_OR;
                    6'b100111: w_aluctl = CTL_NOR;
                    6'b101010: w_aluctl = CTL_SLT;
                    default:   w_aluctl = CTL_ADD;
                endcase
            end
            default: w_aluctl = CTL_ADD;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (w_aluctl)
            CTL_ADD: w_result = a + b;
            CTL_SUB: w_result = a - b;
            CTL_AND: w_result = a & b;
            CTL_OR:  w_result = a | b;
            CTL_NOR: w_result = ~(a | b);
            CTL_SLT: w_result = W'($signed(a) < $signed(b));
            default: w_result = '0;
        endcase
    end

    assign w_zero = (w_result == '0);
    assign aluctl = w_aluctl;
    assign result = w_result;
    assign zero   = w_zero;

    // EX/MEM stage register: rst > clear > hold > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
        end else if (clear) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
        end else if (!hold) begin
            r_result_q <= w_result;
            r_zero_q   <= w_zero;
        end
    end

    assign result_q = r_result_q;
    assign zero_q   = r_zero_q;

endmodule

// File: tb/tb_mips_decode_alu_unit.sv
// Scoreboard bench for mips_decode_alu_unit: decode sweep, ALU vectors and stage-register control.
module tb_mips_decode_alu_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        regdst;
    logic [1:0]  branch;
    logic        memread;
    logic        memtoreg;
    logic [1:0]  aluop;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  aluop_ex;
    logic [5:0]  funct_ex;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluctl;
    logic [31:0] result;
    logic        zero;
    logic        hold;
    logic        clear;
    logic [31:0] result_q;
    logic        zero_q;

    logic [9:0]  ctl_obs;
    int          n_cmp;
    int          n_err;
    logic [31:0] sb_val[$];
    string       sb_tag[$];

    mips_decode_alu_unit #(.W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .regdst   (regdst),
        .branch   (branch),
        .memread  (memread),
        .memtoreg (memtoreg),
        .aluop    (aluop),
        .memwrite (memwrite),
        .alusrc   (alusrc),
        .regwrite (regwrite),
        .aluop_ex (aluop_ex),
        .funct_ex (funct_ex),
        .a        (a),
        .b        (b),
        .aluctl   (aluctl),
        .result   (result),
        .zero     (zero),
        .hold     (hold),
        .clear    (clear),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    assign ctl_obs = {regdst, branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, need finish before 50000");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, need %08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string       t;
        logic [31:0] v;
        if (sb_val.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: got %08h, need a queued expectation", got);
        end else begin
            t = sb_tag.pop_front();
            v = sb_val.pop_front();
            check_val(t, got, v);
        end
    endtask

    task automatic decode_case(input logic [5:0] op, input logic [9:0] exp);
        opcode = op;
        sb_push($sformatf("decode_%06b", op), 32'(exp));
        #1;
        sb_pop(32'(ctl_obs));
    endtask

    task automatic alu_case(input logic [1:0] op, input logic [5:0] f, input logic [31:0] av,
                            input logic [31:0] bv, input logic [3:0] exp_ctl,
                            input logic [31:0] exp_res);
        string base;
        base = $sformatf("alu_%02b_%06b_%08h_%08h", op, f, av, bv);
        aluop_ex = op;
        funct_ex = f;
        a        = av;
        b        = bv;
        sb_push({base, "_ctl"}, 32'(exp_ctl));
        sb_push({base, "_res"}, exp_res);
        sb_push({base, "_zero"}, 32'(exp_res == 32'd0));
        #1;
        sb_pop(32'(aluctl));
        sb_pop(result);
        sb_pop(32'(zero));
    endtask

    // Drive at negedge, push expected register contents, compare just after the next posedge
    task automatic reg_step(input string tag, input logic [31:0] av, input logic h, input logic c,
                            input logic [31:0] exp_q, input logic exp_z);
        @(negedge clk);
        aluop_ex = 2'b00;
        funct_ex = 6'b000000;
        a        = av;
        b        = 32'd0;
        hold     = h;
        clear    = c;
        sb_push({tag, "_q"}, exp_q);
        sb_push({tag, "_zq"}, 32'(exp_z));
        @(posedge clk);
        #1;
        sb_pop(result_q);
        sb_pop(32'(zero_q));
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        opcode   = 6'b000000;
        aluop_ex = 2'b00;
        funct_ex = 6'b000000;
        a        = 32'd0;
        b        = 32'd0;
        hold     = 1'b0;
        clear    = 1'b0;

        @(posedge clk);
        #1;
        sb_push("reset_q", 32'd0);
        sb_push("reset_zq", 32'd0);
        sb_pop(result_q);
        sb_pop(32'(zero_q));
        // Decode is independent of rst
        decode_case(6'b100011, 10'b0_00_1_1_00_0_1_1);

        @(negedge clk);
        rst = 1'b0;

        decode_case(6'b000000, 10'b1_00_0_0_10_0_0_1);
        decode_case(6'b100011, 10'b0_00_1_1_00_0_1_1);
        decode_case(6'b101011, 10'b0_00_0_0_00_1_1_0);
        decode_case(6'b000100, 10'b0_01_0_0_01_0_0_0);
        decode_case(6'b000101, 10'b0_10_0_0_01_0_0_0);
        decode_case(6'b001000, 10'b0_00_0_0_00_0_1_1);
        decode_case(6'b111111, 10'b0);
        decode_case(6'b000010, 10'b0);

        alu_case(2'b10, 6'b100000, 32'd7, 32'd9, 4'b0010, 32'd16);
        alu_case(2'b10, 6'b100010, 32'd7, 32'd9, 4'b0110, 32'hFFFF_FFFE);
        alu_case(2'b10, 6'b101010, 32'd7, 32'd9, 4'b0111, 32'd1);
        alu_case(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 32'h00F0_00F0);
        alu_case(2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 32'hFFF0_FFF0);
        alu_case(2'b10, 6'b100111, 32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF);
        alu_case(2'b10, 6'b101010, 32'h8000_0000, 32'd1, 4'b0111, 32'd1);
        alu_case(2'b10, 6'b101010, 32'd1, 32'h8000_0000, 4'b0111, 32'd0);
        alu_case(2'b01, 6'b100100, 32'd5, 32'd5, 4'b0110, 32'd0);
        alu_case(2'b00, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0);
        alu_case(2'b11, 6'b100111, 32'd3, 32'd4, 4'b0010, 32'd7);
        alu_case(2'b10, 6'b000011, 32'd3, 32'd4, 4'b0010, 32'd7);
        alu_case(2'b10, 6'b100100, 32'h0000_00FF, 32'h0000_0F00, 4'b0000, 32'd0);

        reg_step("load_1234", 32'h1234, 1'b0, 1'b0, 32'h1234, 1'b0);
        reg_step("hold_1",    32'h5555, 1'b1, 1'b0, 32'h1234, 1'b0);
        reg_step("hold_2",    32'h0000, 1'b1, 1'b0, 32'h1234, 1'b0);
        reg_step("clear_hold", 32'h7777, 1'b1, 1'b1, 32'd0, 1'b0);
        reg_step("load_zero", 32'h0000, 1'b0, 1'b0, 32'd0, 1'b1);
        reg_step("hold_zero", 32'h0042, 1'b1, 1'b0, 32'd0, 1'b1);
        reg_step("load_9",    32'h0009, 1'b0, 1'b0, 32'h9, 1'b0);

        // Asynchronous reset between edges, then first capture on the following posedge
        @(negedge clk);
        a    = 32'h0000_00AB;
        hold = 1'b0;
        rst  = 1'b1;
        sb_push("async_rst_q", 32'd0);
        sb_push("async_rst_zq", 32'd0);
        #1;
        sb_pop(result_q);
        sb_pop(32'(zero_q));
        #1;
        rst = 1'b0;
        sb_push("post_rst_q", 32'hAB);
        sb_push("post_rst_zq", 32'd0);
        @(posedge clk);
        #1;
        sb_pop(result_q);
        sb_pop(32'(zero_q));

        check_val("sb_empty", 32'(sb_val.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
